gfx256_render_zwrite: RTL

- Final pixel stage, directly downstream of the alpha blender; consumes its pixel_x/y/z/color + write strobe and returns ack.
- Optional signed 16-bit depth test against the z-buffer: read stored z, compare, then conditionally write color and new z.
- Drives a 256-bit Wishbone-master read port (z fetch) and write port (color, z store); addresses are 32-byte line addresses [31:5] with byte lane selects.

---
 rtl/gfx256_render_zwrite.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gfx256_render_zwrite.sv
// Final pixel stage: optional signed depth test against the z-buffer,
// then a color write and a z write over 256-bit line-addressed ports.
module gfx256_render_zwrite #(
   parameter int point_width = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   zbuffer_enable_i,
   input  logic [31:5]            target_base_i,
   input  logic [31:5]            zbuffer_base_i,
   input  logic [point_width-1:0] target_size_x_i,
   input  logic [1:0]             color_depth_i,
   input  logic [point_width-1:0] pixel_x_i,
   input  logic [point_width-1:0] pixel_y_i,
   input  logic [point_width-1:0] pixel_z_i,
   input  logic [31:0]            pixel_color_i,
   input  logic                   write_i,
   output logic                   ack_o,
   output logic                   z_request_o,
   output logic [31:5]            z_addr_o,
   input  logic [255:0]           z_data_i,
   input  logic                   z_ack_i,
   input  logic                   rd_busy_i,
   output logic                   wr_request_o,
   output logic [31:5]            wr_addr_o,
   output logic [31:0]            wr_sel_o,
   output logic [255:0]           wr_dat_o,
   input  logic                   wr_ack_i
);

   typedef enum logic [2:0] {
      IDLE, Z_READ, WR_COLOR, WR_Z, DONE
   } state_t;

   state_t state, state_nxt;

   logic [point_width-1:0] px, py, pz;
   logic [31:0]            pcolor;
   logic                   zen;
   logic [1:0]             depth;

   logic [31:0]  idx, coff, zoff, csel, zsel;
   logic [255:0] cdat, zdat;
   logic [15:0]  stored;
   logic         pass;

   logic         z_req_nxt, wr_req_nxt;
   logic [31:5]  z_addr_nxt, wr_addr_nxt;
   logic [31:0]  wr_sel_nxt;
   logic [255:0] wr_dat_nxt;

   assign idx  = 32'(target_size_x_i) * 32'(py) + 32'(px);
   assign zoff = idx << 1;
   assign zsel = 32'h3 << zoff[4:0];
   assign zdat = {16{pz[15:0]}};

   // 24- and 30-bit color both occupy a full 32-bit word
   always_comb begin
      coff = idx << 2;
      csel = 32'hF << coff[4:0];
      cdat = {8{pcolor}};
      unique case (1'b1)
         depth == 2'b00: begin
            coff = idx;
            csel = 32'h1 << coff[4:0];
            cdat = {32{pcolor[7:0]}};
         end
         depth == 2'b01: begin
            coff = idx << 1;
            csel = 32'h3 << coff[4:0];
            cdat = {16{pcolor[15:0]}};
         end
         default: ;
      endcase
   end

   assign stored = 16'(z_data_i >> {zoff[4:0], 3'b000});
   assign pass   = $signed(pz[15:0]) < $signed(stored);
   assign ack_o  = (state == DONE);

   always_comb begin
      state_nxt   = state;
      z_req_nxt   = 1'b0;
      wr_req_nxt  = 1'b0;
      z_addr_nxt  = z_addr_o;
      wr_addr_nxt = wr_addr_o;
      wr_sel_nxt  = wr_sel_o;
      wr_dat_nxt  = wr_dat_o;
      unique case (state)
         IDLE: begin
            if (write_i)
               state_nxt = zbuffer_enable_i ? Z_READ : WR_COLOR;
         end
         Z_READ: begin
            z_addr_nxt = zbuffer_base_i + zoff[31:5];
            if (z_request_o && z_ack_i)
               state_nxt = pass ? WR_COLOR : DONE;
            else
               z_req_nxt = z_request_o | ~rd_busy_i;
         end
         WR_COLOR: begin
            wr_addr_nxt = target_base_i + coff[31:5];
            wr_sel_nxt  = csel;
            wr_dat_nxt  = cdat;
            if (wr_request_o && wr_ack_i)
               state_nxt = zen ? WR_Z : DONE;
            else
               wr_req_nxt = 1'b1;
         end
         WR_Z: begin
            wr_addr_nxt = zbuffer_base_i + zoff[31:5];
            wr_sel_nxt  = zsel;
            wr_dat_nxt  = zdat;
            if (wr_request_o && wr_ack_i)
               state_nxt = DONE;
            else
               wr_req_nxt = 1'b1;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         z_request_o  <= 1'b0;
         z_addr_o     <= '0;
         wr_request_o <= 1'b0;
         wr_addr_o    <= '0;
         wr_sel_o     <= '0;
         wr_dat_o     <= '0;
      end else begin
         state        <= state_nxt;
         z_request_o  <= z_req_nxt;
         z_addr_o     <= z_addr_nxt;
         wr_request_o <= wr_req_nxt;
         wr_addr_o    <= wr_addr_nxt;
         wr_sel_o     <= wr_sel_nxt;
         wr_dat_o     <= wr_dat_nxt;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         px     <= '0;
         py     <= '0;
         pz     <= '0;
         pcolor <= '0;
         zen    <= 1'b0;
         depth  <= 2'b00;
      end else if (state == IDLE && write_i) begin
         px     <= pixel_x_i;
         py     <= pixel_y_i;
         pz     <= pixel_z_i;
         pcolor <= pixel_color_i;
         zen    <= zbuffer_enable_i;
         depth  <= color_depth_i;
      end
   end

endmodule
